// File: rtl/data_sync_launcher_pkg.sv
// rtl/data_sync_launcher_pkg.sv - shared CDC launcher state encoding and sync-depth floor
package data_sync_launcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    REQ  = 2'b10,
    REL  = 2'b11
  } cdc_state_t;

  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - multi-flop synchronizer for single-bit/level signals
module bit_synchronizer #(
  parameter int BUS_WIDTH  = 1,
  parameter int NUM_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] data_in,
  output logic [BUS_WIDTH-1:0] data_out
);

  logic [BUS_WIDTH-1:0] sync_q [NUM_STAGES];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NUM_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= data_in;
      for (int i = 1; i < NUM_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign data_out = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_launcher.sv
// rtl/data_sync_launcher.sv - source-side 4-phase req/ack launcher with one-word holding register
module data_sync_launcher
  import data_sync_launcher_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] src_data,
  input  logic                 src_valid,
  output logic                 src_ready,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  input  logic                 bus_ack,
  output logic                 done_pulse,
  output logic                 busy
);

  // Never build a synchronizer shallower than the metastability floor.
  localparam int SYNC_STAGES = (NUM_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : NUM_STAGES;

  cdc_state_t           state, state_nxt;
  logic                 ack_s;
  logic [BUS_WIDTH-1:0] hold_data;
  logic                 hold_vld;
  logic                 launch;
  logic                 bus_enable_nxt;
  logic                 done_nxt;

  bit_synchronizer #(
    .BUS_WIDTH (1),
    .NUM_STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .CLK     (CLK),
    .RST     (RST),
    .data_in (bus_ack),
    .data_out(ack_s)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hold_vld) state_nxt = LOAD;
      LOAD:    state_nxt = REQ;
      REQ:     if (ack_s) state_nxt = REL;
      REL:     if (!ack_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs; nothing here reaches a port directly.
  always_comb begin
    launch         = 1'b0;
    bus_enable_nxt = bus_enable;
    done_nxt       = 1'b0;
    case (state)
      IDLE:    launch = hold_vld;
      LOAD:    bus_enable_nxt = 1'b1;
      REQ:     if (ack_s) bus_enable_nxt = 1'b0;
      REL:     if (!ack_s) done_nxt = 1'b1;
      default: bus_enable_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hold_data  <= '0;
      hold_vld   <= 1'b0;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      if (src_valid && src_ready) begin
        hold_data <= src_data;
        hold_vld  <= 1'b1;
      end else if (launch) begin
        hold_vld <= 1'b0;
      end
      if (launch) unsync_bus <= hold_data;
      bus_enable <= bus_enable_nxt;
      done_pulse <= done_nxt;
    end
  end

  assign src_ready = !hold_vld;
  assign busy      = (state != IDLE) || hold_vld;

endmodule

// File: tb/tb_data_sync_launcher.sv
// tb/tb_data_sync_launcher.sv - scoreboard bench for data_sync_launcher with ack loopback model
module tb_data_sync_launcher;

  localparam int BUS_WIDTH  = 8;
  localparam int NUM_STAGES = 2;
  localparam int ACK_LOOP   = 3;

  logic                 CLK;
  logic                 RST;
  logic [BUS_WIDTH-1:0] src_data;
  logic                 src_valid;
  logic                 src_ready;
  logic [BUS_WIDTH-1:0] unsync_bus;
  logic                 bus_enable;
  logic                 bus_ack;
  logic                 done_pulse;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [BUS_WIDTH-1:0] exp_q[$];
  logic                 loop_en    = 1'b1;
  logic                 manual_ack = 1'b0;
  logic [ACK_LOOP-1:0]  ack_pipe;

  bit                   active;
  bit                   expect_b2b;
  bit                   stable_ok;
  int                   rise_cyc;
  int                   done_cyc;
  int                   n_done = 0;
  int                   n_rise = 0;
  logic                 prev_en;
  logic                 prev_done;
  logic [BUS_WIDTH-1:0] prev_bus;
  logic [BUS_WIDTH-1:0] cur_word;

  data_sync_launcher #(
    .BUS_WIDTH (BUS_WIDTH),
    .NUM_STAGES(NUM_STAGES)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .unsync_bus(unsync_bus),
    .bus_enable(bus_enable),
    .bus_ack   (bus_ack),
    .done_pulse(done_pulse),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Destination model: bus_ack is bus_enable seen on the third falling edge after it changes.
  always @(negedge CLK or negedge RST) begin
    if (!RST) ack_pipe <= '0;
    else      ack_pipe <= {ack_pipe[ACK_LOOP-2:0], bus_enable};
  end
  assign bus_ack = loop_en ? ack_pipe[ACK_LOOP-1] : manual_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected word whenever a request is raised and checks timing rules.
  always @(negedge CLK or negedge RST) begin
    if (!RST) begin
      exp_q.delete();
      active     = 1'b0;
      expect_b2b = 1'b0;
      stable_ok  = 1'b1;
      prev_en    = 1'b0;
      prev_done  = 1'b0;
      prev_bus   = '0;
      n_rise     = n_done;
    end else begin
      if (bus_enable && !prev_en) begin
        n_rise++;
        check("launch_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          cur_word = exp_q.pop_front();
          check("launch_data", 32'(unsync_bus), 32'(cur_word));
          check("data_leads_enable", 32'(prev_bus), 32'(cur_word));
        end else begin
          cur_word = unsync_bus;
        end
        check("busy_in_transfer", 32'(busy), 32'd1);
        if (expect_b2b) check("b2b_idle_gap", 32'(cyc - done_cyc), 32'd2);
        expect_b2b = 1'b0;
        active     = 1'b1;
        stable_ok  = 1'b1;
        rise_cyc   = cyc;
      end
      if (active && unsync_bus !== cur_word) stable_ok = 1'b0;
      if (!bus_enable && prev_en && loop_en)
        check("enable_width", 32'(cyc - rise_cyc), 32'(NUM_STAGES + 3));
      if (done_pulse) begin
        n_done++;
        check("done_single_cycle", 32'(prev_done), 32'd0);
        check("done_in_transfer", 32'(active), 32'd1);
        check("bus_stable", 32'(stable_ok), 32'd1);
        active     = 1'b0;
        done_cyc   = cyc;
        expect_b2b = !src_ready;
      end
      prev_en   = bus_enable;
      prev_done = done_pulse;
      prev_bus  = unsync_bus;
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send(input logic [BUS_WIDTH-1:0] d, output int stall);
    stall     = 0;
    src_valid = 1'b1;
    src_data  = d;
    while (!src_ready && stall < 400) begin
      @(negedge CLK);
      stall++;
    end
    if (src_ready) begin
      exp_q.push_back(d);
      @(negedge CLK);
    end else begin
      check("send_timeout", 32'd0, 32'd1);
    end
    src_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((busy || active || exp_q.size() != 0) && t < budget) begin
      @(negedge CLK);
      t++;
    end
    if (t >= budget) check("idle_timeout", 32'd0, 32'd1);
    @(negedge CLK);
  endtask

  task automatic wait_enable(input int budget);
    int t = 0;
    while (!bus_enable && t < budget) begin
      @(negedge CLK);
      t++;
    end
    if (t >= budget) check("enable_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int base;
    RST       = 1'b0;
    src_valid = 1'b1;
    src_data  = 8'hFF;
    repeat (3) @(negedge CLK);
    check("rst_unsync_bus", 32'(unsync_bus), 32'd0);
    check("rst_bus_enable", 32'(bus_enable), 32'd0);
    check("rst_src_ready", 32'(src_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_pulse), 32'd0);
    src_valid = 1'b0;
    RST       = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_nothing_accepted", 32'(busy), 32'd0);

    base = n_done;
    send(8'hA5, st);
    check("lat_edge0_bus", 32'(unsync_bus), 32'd0);
    check("lat_edge0_en", 32'(bus_enable), 32'd0);
    @(negedge CLK);
    check("lat_edge1_bus", 32'(unsync_bus), 32'hA5);
    check("lat_edge1_en", 32'(bus_enable), 32'd0);
    @(negedge CLK);
    check("lat_edge2_en", 32'(bus_enable), 32'd1);
    wait_idle(200);
    check("single_done_count", 32'(n_done - base), 32'd1);

    base = n_done;
    send(8'h11, st);
    wait_enable(50);
    send(8'h22, st);
    check("b2b_ready_drop", 32'(src_ready), 32'd0);
    send(8'h33, st);
    check("hold_full_stalled", 32'(st > 0), 32'd1);
    wait_idle(300);
    check("b2b_done_count", 32'(n_done - base), 32'd3);

    base       = n_done;
    loop_en    = 1'b0;
    manual_ack = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      check("spur_no_enable", 32'(bus_enable), 32'd0);
      check("spur_not_busy", 32'(busy), 32'd0);
    end
    manual_ack = 1'b0;
    repeat (NUM_STAGES + 2) @(negedge CLK);
    check("spur_no_done", 32'(n_done - base), 32'd0);
    loop_en = 1'b1;
    send(8'h3C, st);
    wait_idle(200);
    check("spur_then_xfer", 32'(n_done - base), 32'd1);

    send(8'hC3, st);
    wait_enable(50);
    repeat (2) @(negedge CLK);
    send(8'hD4, st);
    #3 RST = 1'b0;
    #1;
    check("mrst_bus_enable", 32'(bus_enable), 32'd0);
    check("mrst_unsync_bus", 32'(unsync_bus), 32'd0);
    check("mrst_hold_cleared", 32'(src_ready), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    base = n_done;
    send(8'h5A, st);
    wait_idle(200);
    check("post_reset_done", 32'(n_done - base), 32'd1);
    check("post_reset_bus", 32'(unsync_bus), 32'h5A);

    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 10)) @(negedge CLK);
      send(8'($urandom), st);
    end
    wait_idle(2000);
    check("end_ready", 32'(src_ready), 32'd1);
    check("end_not_busy", 32'(busy), 32'd0);
    check("end_rise_done_match", 32'(n_done), 32'(n_rise));
    check("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
